stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//  MM:SS stopwatch core, directly downstream of the clock divider.
//  Consumes the divider's clk_1hz / clk_2hz level outputs, edge-detects them in the system clock domain.
//  Keeps four BCD digits with run, pause, clear and adjust modes.
//  Digit outputs feed the 7-segment display mux.
// PARAMETERS
//  MIN_TENS_MAX  5  highest minute-tens digit (legal 1..9); full-scale time is MIN_TENS_MAX9:59
//  SYNC_EN       1  1 = 2-FF synchronizer on clk_1hz/clk_2hz (latency 3); 0 = edge detect only (latency 1)
// PORTS
//  clk        in   1  system clock, 100 MHz
//  rst        in   1  asynchronous, active-low reset; asserts immediately, deasserts on clk posedge
//  clk_1hz    in   1  divider 1 Hz level; each rising edge = one count tick
//  clk_2hz    in   1  divider 2 Hz level; each rising edge = one adjust tick
//  pause      in   1  single-cycle debounced pulse; toggles RUN/PAUSE
//  clr        in   1  single-cycle debounced pulse; clears digits to 00:00
//  adj        in   1  level; 1 = ADJUST mode
//  sel        in   1  adjust field select: 0 = minutes, 1 = seconds
//  min_tens   out  4  BCD 0..MIN_TENS_MAX
//  min_ones   out  4  BCD 0..9
//  sec_tens   out  4  BCD 0..5
//  sec_ones   out  4  BCD 0..9
//  running    out  1  1 while state == RUN
//  wrap       out  1  one-cycle pulse when RUN count rolls full-scale -> 00:00
// BEHAVIOUR
//  Reset (rst=0): state=PAUSE; all digits=0; running=0; wrap=0; sync/edge registers=0.
//  Tick: t1 = s_last & ~s_prev on the (synchronized) clk_1hz; t2 likewise on clk_2hz. Each is one clk wide.
//  Latency (SYNC_EN=1): clk_1hz sampled high at edge N -> digits change at edge N+2 (3rd edge incl. N).
//  States: PAUSE, RUN, ADJUST (2-bit encoded; all outputs registered).
//   PAUSE : pause -> RUN; adj=1 -> ADJUST.
//   RUN   : pause -> PAUSE; adj=1 -> ADJUST.
//   ADJUST: adj=0 -> PAUSE. pause is ignored.
//   adj=1 has priority over pause in the same cycle.
//  RUN count on t1:
//   sec_ones+1; 9 -> 0 with carry into sec_tens.
//   sec_tens 5 -> 0 with carry into min_ones.
//   min_ones 9 -> 0 with carry into min_tens.
//   min_tens MIN_TENS_MAX -> 0.
//   Full-scale -> 00:00 asserts wrap for exactly that cycle.
//  PAUSE: t1 and t2 ignored; digits hold.
//  ADJUST on t2: the selected 2-digit field increments by 1.
//   Seconds: 59 -> 00. Minutes: MIN_TENS_MAX9 -> 00.
//   No carry into the other field; wrap stays 0.
//   t1 is ignored in ADJUST.
//  sel may change at any time; it takes effect on the next t2.
//  clr: digits <= 0 on the next edge; state unchanged; wrap=0.
//   clr has priority over a same-cycle t1/t2.
//  pause and t1 in the same cycle: the count uses the current state (RUN counts once), then the state toggles.
//  Edges of clk_1hz arriving while not in RUN are discarded, not queued.
//   No burst counting on return to RUN.
//  rst asserted mid-count: immediate return to the reset values above; the first tick after reset requires a fresh 0->1 edge.
//  Digits never leave their legal BCD range; illegal values are unreachable.
// TESTING
//  1. Reset, pause pulse, 60 clk_1hz edges -> running=1, digits 01:00; each change lands 3 clks after the edge.
//  2. Preload 59:59 via ADJUST, return to RUN, one clk_1hz edge -> 00:00 and wrap=1 for exactly 1 clk.
//  3. adj=1, sel=1, 61 clk_2hz edges from 00:00 -> 00:01 (seconds wrapped 59 -> 00 with no carry); clk_1hz edges ignored.
//  4. RUN at 00:09: clr and t1 in the same cycle -> 00:00, state stays RUN; next t1 -> 00:01.
//  5. RUN: pause coincident with t1 -> count +1, then running=0; 5 further clk_1hz edges -> digits unchanged.
//  6. rst pulled low mid-count at 12:34 (asynchronous, between edges) -> digits 00:00 and running=0 immediately; after release, clk_1hz held high -> no tick.

Source files
------------

// File: rtl/stopwatch_counter.sv
// ============================================================================
// Module      : stopwatch_counter
// Description : MM:SS BCD stopwatch core with run, pause, clear and adjust
//               modes, ticked by edge-detected divider levels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter #(
    parameter int MIN_TENS_MAX = 5,
    parameter bit SYNC_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       pause,
    input  logic       clr,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       wrap
);

    localparam logic [3:0] MT_MAX = MIN_TENS_MAX[3:0];

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    logic [1:0] lvl_raw;
    logic [1:0] lvl;
    logic [1:0] lvl_prev;
    logic [1:0] armed;
    logic [1:0] ticks;
    logic       lvl_valid;
    logic       t1;
    logic       t2;

    assign lvl_raw = {clk_2hz, clk_1hz};

    generate
        if (SYNC_EN) begin : g_sync
            logic [1:0] meta;
            logic [1:0] stable;
            logic [1:0] fill;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta   <= 2'b00;
                    stable <= 2'b00;
                    fill   <= 2'b00;
                end else begin
                    meta   <= lvl_raw;
                    stable <= meta;
                    fill   <= {fill[0], 1'b1};
                end
            end
            assign lvl       = stable;
            assign lvl_valid = fill[1];
        end else begin : g_nosync
            assign lvl       = lvl_raw;
            assign lvl_valid = 1'b1;
        end
    endgenerate

    // A tick needs a low level seen after reset, so a level already high
    // when reset releases never produces a spurious tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_prev <= 2'b00;
            armed    <= 2'b00;
        end else begin
            lvl_prev <= lvl;
            armed    <= armed | ({2{lvl_valid}} & ~lvl);
        end
    end

    assign ticks = lvl & ~lvl_prev & armed;
    assign t1    = ticks[0];
    assign t2    = ticks[1];

    state_t     state;
    state_t     state_next;
    logic [3:0] mt_next;
    logic [3:0] mo_next;
    logic [3:0] st_next;
    logic [3:0] so_next;
    logic       wrap_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_PAUSE;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            running  <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_next;
            min_tens <= mt_next;
            min_ones <= mo_next;
            sec_tens <= st_next;
            sec_ones <= so_next;
            running  <= (state_next == ST_RUN);
            wrap     <= wrap_next;
        end
    end

    always_comb begin
        state_next = state;
        mt_next    = min_tens;
        mo_next    = min_ones;
        st_next    = sec_tens;
        so_next    = sec_ones;
        wrap_next  = 1'b0;

        case (state)
            ST_PAUSE:  if (pause) state_next = ST_RUN;
            ST_RUN:    if (pause) state_next = ST_PAUSE;
            ST_ADJUST: if (!adj)  state_next = ST_PAUSE;
            default:   state_next = ST_PAUSE;
        endcase
        if (adj) state_next = ST_ADJUST;

        // Counting uses the current state, so a pause coinciding with t1 still counts once.
        if (clr) begin
            mt_next = 4'd0;
            mo_next = 4'd0;
            st_next = 4'd0;
            so_next = 4'd0;
        end else if (state == ST_RUN && t1) begin
            if (sec_ones == 4'd9) begin
                so_next = 4'd0;
                if (sec_tens == 4'd5) begin
                    st_next = 4'd0;
                    if (min_ones == 4'd9) begin
                        mo_next = 4'd0;
                        if (min_tens == MT_MAX) begin
                            mt_next   = 4'd0;
                            wrap_next = 1'b1;
                        end else begin
                            mt_next = min_tens + 4'd1;
                        end
                    end else begin
                        mo_next = min_ones + 4'd1;
                    end
                end else begin
                    st_next = sec_tens + 4'd1;
                end
            end else begin
                so_next = sec_ones + 4'd1;
            end
        end else if (state == ST_ADJUST && t2) begin
            if (sel) begin
                if (sec_ones == 4'd9) begin
                    so_next = 4'd0;
                    st_next = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
                end else begin
                    so_next = sec_ones + 4'd1;
                end
            end else begin
                if (min_ones == 4'd9) begin
                    mo_next = 4'd0;
                    mt_next = (min_tens == MT_MAX) ? 4'd0 : min_tens + 4'd1;
                end else begin
                    mo_next = min_ones + 4'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// Module      : tb_stopwatch_counter
// Description : Directed scoreboard bench for stopwatch_counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

    localparam int MIN_TENS_MAX = 5;
    localparam int MAX_MIN      = MIN_TENS_MAX * 10 + 9;

    logic       clk;
    logic       rst;
    logic       clk_1hz;
    logic       clk_2hz;
    logic       pause;
    logic       clr;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       wrap;

    stopwatch_counter #(
        .MIN_TENS_MAX(MIN_TENS_MAX),
        .SYNC_EN     (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_1hz (clk_1hz),
        .clk_2hz (clk_2hz),
        .pause   (pause),
        .clr     (clr),
        .adj     (adj),
        .sel     (sel),
        .min_tens(min_tens),
        .min_ones(min_ones),
        .sec_tens(sec_tens),
        .sec_ones(sec_ones),
        .running (running),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [17:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: plain minute/second integers
    int mm    = 0;
    int ss    = 0;
    bit run_m = 1'b0;
    bit wrap_m = 1'b0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag);
        exp_t e;
        e.tag = tag;
        e.val = {run_m, wrap_m, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        exp_q.push_back(e);
        wrap_m = 1'b0;
    endtask

    task automatic check();
        exp_t        e;
        logic [17:0] obs;
        obs = {running, wrap, min_tens, min_ones, sec_tens, sec_ones};
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty: observed %h required <entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s: observed run/wrap/digits=%h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    // kind: 0 = counting t1, 1 = t1 ignored, 2 = adjust seconds, 3 = adjust minutes
    task automatic model_apply(input int kind);
        case (kind)
            0: begin
                ss++;
                if (ss == 60) begin
                    ss = 0;
                    mm++;
                    if (mm > MAX_MIN) begin
                        mm     = 0;
                        wrap_m = 1'b1;
                    end
                end
            end
            2: ss = (ss + 1) % 60;
            3: mm = (mm + 1) % (MAX_MIN + 1);
            default: ;
        endcase
    endtask

    task automatic pulse(input int kind, input string tag, input bit lat);
        if (lat) push({tag, "_hold"});
        model_apply(kind);
        push(tag);
        if (kind >= 2) clk_2hz = 1'b1;
        else           clk_1hz = 1'b1;
        step(2);
        if (lat) check();
        step(1);
        check();
        clk_1hz = 1'b0;
        clk_2hz = 1'b0;
        step(3);
    endtask

    task automatic pause_pulse();
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        run_m = ~run_m;
    endtask

    initial begin
        rst = 1'b0; clk_1hz = 1'b0; clk_2hz = 1'b0;
        pause = 1'b0; clr = 1'b0; adj = 1'b0; sel = 1'b0;
        step(2);
        push("reset");
        check();
        rst = 1'b1;
        step(4);

        // Run 60 seconds from 00:00 with latency check on the first edge
        pause_pulse();
        push("run_start");
        check();
        pulse(0, "t1_first", 1'b1);
        for (int i = 1; i < 60; i++) pulse(0, "t1_count", (i == 59));

        // Preload 59:59 in adjust mode, then roll over
        adj = 1'b1; run_m = 1'b0; step(1);
        sel = 1'b0;
        for (int i = 0; i < 58; i++) pulse(3, "adj_min", 1'b0);
        sel = 1'b1;
        for (int i = 0; i < 59; i++) pulse(2, "adj_sec", 1'b0);
        push("preload_5959");
        check();
        adj = 1'b0; step(1);
        pause_pulse();
        model_apply(0);
        push("rollover_wrap");
        clk_1hz = 1'b1;
        step(3);
        check();
        step(1);
        push("wrap_one_cycle");
        check();
        clk_1hz = 1'b0;
        step(3);

        // Seconds adjust wraps without carry; t1 ignored in adjust
        adj = 1'b1; sel = 1'b1; run_m = 1'b0; step(1);
        for (int i = 0; i < 61; i++) begin
            pulse(2, "adj_sec_wrap", (i == 59));
            if (i % 20 == 0) pulse(1, "adj_t1_ignored", 1'b0);
        end
        sel = 1'b0;
        for (int i = 0; i < 60; i++) pulse(3, "adj_min_wrap", (i == 59));

        // clr coincident with t1 while running at 00:09
        adj = 1'b0; step(1);
        pause_pulse();
        for (int i = 0; i < 8; i++) pulse(0, "t1_to_09", (i == 7));
        clk_1hz = 1'b1;
        step(2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        mm = 0; ss = 0;
        push("clr_beats_t1");
        check();
        clk_1hz = 1'b0;
        step(3);
        pulse(0, "t1_after_clr", 1'b0);

        // pause coincident with t1: counts once, then stops
        model_apply(0);
        clk_1hz = 1'b1;
        step(2);
        pause_pulse();
        push("pause_with_t1");
        check();
        clk_1hz = 1'b0;
        step(3);
        for (int i = 0; i < 5; i++) pulse(1, "paused_t1_ignored", 1'b0);

        // Preload 12:34, run, then async reset between edges
        adj = 1'b1; sel = 1'b0; step(1);
        mm = 0; ss = 0;
        clr = 1'b1; step(1); clr = 1'b0;
        for (int i = 0; i < 12; i++) pulse(3, "adj_to_12", 1'b0);
        sel = 1'b1;
        for (int i = 0; i < 34; i++) pulse(2, "adj_to_34", 1'b0);
        adj = 1'b0; step(1);
        pause_pulse();
        push("at_1234");
        check();
        clk_1hz = 1'b1;
        step(1);
        #2;
        rst = 1'b0;
        mm = 0; ss = 0; run_m = 1'b0;
        #1;
        push("async_reset");
        check();
        @(negedge clk);
        rst = 1'b1;
        step(1);
        pause_pulse();
        step(6);
        push("no_tick_held_high");
        check();
        clk_1hz = 1'b0;
        step(3);
        pulse(0, "fresh_edge_tick", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: observed no completion required completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
